// File: rtl/wired_inst_queue.sv
// Instruction queue between a two-wide decoder and the backend.
// Pairs are compacted on push and presented oldest-first as a pair.
module wired_inst_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [1:0]              in_mask_i,
    input  logic [2*WIDTH-1:0]      in_data_i,
    output logic                    pkg_valid_o,
    input  logic                    pkg_ready_i,
    output logic [1:0]              pkg_mask_o,
    output logic [2*WIDTH-1:0]      pkg_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    rd;
    logic [AW-1:0]    wr;
    logic [AW-1:0]    rd_nxt1;
    logic [AW-1:0]    wr_nxt1;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    push_n;
    logic [CW-1:0]    pop_n;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] wdata0;

    assign d0 = in_data_i[WIDTH-1:0];
    assign d1 = in_data_i[2*WIDTH-1:WIDTH];

    // Ready depends only on registered occupancy so it never loops back
    // through the backend handshake or the flush path.
    assign in_ready_o  = (cnt <= CW'(DEPTH - 2));
    assign push        = in_valid_i && in_ready_o && !flush_i;

    assign pkg_valid_o = (cnt != '0);
    assign pkg_mask_o  = {(cnt >= CW'(2)), (cnt >= CW'(1))};
    assign pop         = pkg_valid_o && pkg_ready_i && !flush_i;

    assign push_n = push ? (CW'(in_mask_i[0]) + CW'(in_mask_i[1])) : '0;
    assign pop_n  = pop  ? (CW'(pkg_mask_o[0]) + CW'(pkg_mask_o[1])) : '0;

    assign wr_nxt1 = wr + AW'(1);
    assign rd_nxt1 = rd + AW'(1);

    // A lone slot1 instruction is compacted down into the entry at wr.
    assign wdata0 = in_mask_i[0] ? d0 : d1;

    assign pkg_o   = {mem[rd_nxt1], mem[rd]};
    assign count_o = cnt;

    always_ff @(posedge clk) begin
        if (push && (in_mask_i != 2'b00)) begin
            mem[wr] <= wdata0;
        end
        if (push && (in_mask_i == 2'b11)) begin
            mem[wr_nxt1] <= d1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else begin
            wr  <= wr + push_n[AW-1:0];
            rd  <= rd + pop_n[AW-1:0];
            cnt <= cnt + push_n - pop_n;
        end
    end

endmodule
